// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS main controller
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared memory port.
module mc_ctrl #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       if_extend,
  output logic [4:0] aluop,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;

  state_t cur, nxt;
  logic       is_r, r_ok, is_alui, is_mem, legal;
  logic [4:0] r_aluop, i_aluop;

  always_comb begin
    is_r    = (op == OP_R);
    r_ok    = 1'b1;
    r_aluop = 5'd0;
    case (funct)
      6'h20:   r_aluop = 5'd0;
      6'h21:   r_aluop = 5'd1;
      6'h23:   r_aluop = 5'd2;
      6'h24:   r_aluop = 5'd3;
      6'h25:   r_aluop = 5'd4;
      6'h2A:   r_aluop = 5'd5;
      default: r_ok = 1'b0;
    endcase
    is_alui = 1'b1;
    i_aluop = 5'd0;
    case (op)
      OP_ADDI:  i_aluop = 5'd0;
      OP_ADDIU: i_aluop = 5'd1;
      OP_ANDI:  i_aluop = 5'd3;
      OP_ORI:   i_aluop = 5'd4;
      OP_LUI:   i_aluop = 5'd6;
      default:  is_alui = 1'b0;
    endcase
    is_mem = (op == OP_LW) || (op == OP_SW);
    legal  = (is_r && r_ok) || is_alui || is_mem || (op == OP_BEQ) || (op == OP_J);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt        = cur;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    if_extend  = 1'b0;
    aluop      = 5'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (cur)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = DECODE;
        end
      end
      DECODE: begin
        if (!legal) begin
          illegal = 1'b1;
          if (ILLEGAL_TRAP) begin
            nxt = HALT;
          end else begin
            instr_done = 1'b1;
            nxt        = FETCH;
          end
        end else if (op == OP_J) begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
          nxt        = FETCH;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        if (is_r) begin
          aluop = r_aluop;
          nxt   = WB;
        end else if (is_alui) begin
          aluop     = i_aluop;
          alu_src   = 1'b1;
          if_extend = (op == OP_ADDI) || (op == OP_ADDIU);
          nxt       = WB;
        end else if (is_mem) begin
          alu_src   = 1'b1;
          if_extend = 1'b1;
          nxt       = MEM;
        end else begin
          // beq: compare via subtraction, branch only on a zero result
          aluop      = 5'd2;
          pc_write   = alu_zero;
          pc_src     = alu_zero ? 2'd1 : 2'd0;
          instr_done = 1'b1;
          nxt        = FETCH;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (op == OP_SW);
        if (mem_ready) begin
          instr_done = (op == OP_SW);
          nxt        = (op == OP_SW) ? FETCH : WB;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        reg_dst    = !is_r;
        mem_to_reg = (op == OP_LW);
        nxt        = FETCH;
      end
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
    // Reset gates every output the same cycle, independent of the state register.
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      if_extend  = 1'b0;
      aluop      = 5'd0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state = rst ? 3'd0 : cur;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS core. It replaces the single-cycle opcode/funct decoder with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. Each step drives the existing ALU opcode encoding and datapath selects. It also stalls on a shared instruction/data memory port through a req/ready handshake, and sits between the IR/ALU/register file and the unified memory interface.

## Interface
- `ILLEGAL_TRAP`, default 0: 1 = unsupported opcode/funct parks the FSM in HALT; 0 = it is treated as a NOP.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  6  IR[31:26]; stable from the cycle after `ir_write`.
- `funct`  in  6  IR[5:0].
- `alu_zero`  in  1  ALU zero flag, valid in EXEC.
- `mem_ready`  in  1  memory completes the current `mem_req` this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  store, qualifies `mem_req`.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load IR.
- `pc_write`  out  1  load PC.
- `pc_src`  out  2  next-PC select: 0 = PC+4, 1 = branch target, 2 = jump target.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  1  destination select: 0 = rd, 1 = rt.
- `mem_to_reg`  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- `alu_src`  out  1  ALU B operand select: 0 = rt, 1 = immediate.
- `if_extend`  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- `aluop`  out  5  ALU opcode: add 0, addu 1, subu 2, and 3, or 4, slt 5, lui 6.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse on an undecodable instruction.
- `state`  out  3  current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 7.
- Supported R-type: add, addu, subu, and, or, slt.
- Supported I-type: addi 08, addiu 09, andi 0C, ori 0D, lui 0F, lw 23, sw 2B, beq 04.
- Supported jump: j 02.
- FETCH:
  - Drives `mem_req`=1, `iord`=0.
  - Holds until `mem_ready`.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=0, then goes to DECODE.
- DECODE (1 cycle):
  - j: `pc_write`=1, `pc_src`=2, `instr_done`=1, then FETCH.
  - Any other legal instruction: EXEC.
  - Illegal: `illegal`=1, then HALT if `ILLEGAL_TRAP`=1, else FETCH with `instr_done`=1.
- EXEC:
  - R-type: `aluop` from funct, `alu_src`=0, then WB.
  - I-type ALU: `alu_src`=1, `aluop` per op, then WB. `if_extend`=1 for addi/addiu, 0 for andi/ori/lui.
  - lw/sw: `aluop`=add, `alu_src`=1, `if_extend`=1, then MEM.
  - beq: `aluop`=subu, `alu_src`=0. If `alu_zero`, `pc_write`=1 with `pc_src`=1. Asserts `instr_done`=1, then FETCH.
- MEM:
  - Drives `mem_req`=1, `iord`=1, `mem_we`=(op==sw).
  - Holds until `mem_ready`.
  - sw: `instr_done`=1, then FETCH. lw: then WB.
- WB:
  - Drives `reg_write`=1 and `instr_done`=1, then FETCH.
  - `reg_dst`=0 for R-type, 1 otherwise.
  - `mem_to_reg`=1 only for lw.
- HALT: absorbing; all enables 0. Only `rst` exits it.
- Outputs are Moore/Mealy combinational functions of the state register, `op`, `funct`, `alu_zero` and `mem_ready`. Outputs not listed for a state are 0.

## Timing
- `rst` high asynchronously forces `state`=FETCH and gates every output to 0, including `mem_req`.
- First `mem_req` is in the first cycle after reset deasserts.
- Latency with zero-wait memory:
  - j: 2 cycles.
  - beq: 3 cycles.
  - R-type and I-type ALU: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle on `mem_ready` adds 1 cycle in FETCH or MEM.
- `mem_req` stays high and address/`mem_we` stay stable until the `mem_ready` cycle. `mem_req` deasserts the cycle after `mem_ready`, unless the next state also requests.
- `mem_ready` without `mem_req` is ignored.
- `instr_done` and `illegal` are strictly one cycle per instruction.
- Reset mid-MEM abandons the access: no `reg_write` and no `pc_write`.

## Test plan
- Reset release, IR=addu r3,r1,r2, `mem_ready` always 1:
  - states go 0 → 1 → 2 → 4 → 0.
  - `aluop`=1 in EXEC; `reg_write`=1, `reg_dst`=0 in WB.
  - `instr_done` at cycle 4.
- lw with `mem_ready` delayed 3 cycles in MEM:
  - `mem_req`=1 and `iord`=1 held for 4 cycles, `mem_we`=0.
  - WB has `mem_to_reg`=1, `reg_dst`=1.
  - Total 8 cycles.
- beq:
  - `alu_zero`=1: `pc_write`=1, `pc_src`=1 in EXEC.
  - `alu_zero`=0: `pc_write`=0.
  - Both return to FETCH after 3 cycles.
- ori then lui:
  - ori: EXEC `aluop`=4, `if_extend`=0, `alu_src`=1.
  - lui: EXEC `aluop`=6.
- op=3F:
  - `ILLEGAL_TRAP`=0: `illegal` pulse in DECODE, then FETCH.
  - `ILLEGAL_TRAP`=1: `state`=7 held until `rst`.
- Assert `rst` during FETCH wait and during MEM: all outputs go 0 the same cycle and `state`=0.
